// File: rtl/sequence_playback_ctrl.sv
// sequence_playback_ctrl
//   Plays back the first `length` symbols of the game sequence on the
//   7-segment display path. Each symbol is shown for a fixed on-time and
//   is followed by a blank gap, including after the final symbol.
//
//   Optional build macro: PLAYBACK_SPEEDUP_EN
//     When defined, playbacks longer than 8 symbols show each symbol for
//     ON_TICKS/2 cycles (minimum 1). The gap length is unchanged.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   1-cycle playback request, honoured only in IDLE
//   abort        in   synchronous cancel back to IDLE, no done pulse
//   length[4:0]  in   symbols to play, clamped to MAX_LEN, sampled on start
//   seq_addr     out  index into the sequence source
//   seq_symbol   in   symbol at seq_addr, valid in the same cycle
//   disp_symbol  out  registered symbol for the display decoder
//   disp_valid   out  1 = show disp_symbol, 0 = blank digit
//   busy         out  high in SHOW, GAP and DONE
//   done         out  1-cycle pulse when playback completes
//
// State table
//   IDLE | waiting for start, seq_addr held at 0
//   SHOW | current symbol displayed, on-time running
//   GAP  | digit blanked, off-time running
//   DONE | playback complete, done pulse issued
module sequence_playback_ctrl #(
  parameter int ON_TICKS  = 25000000,
  parameter int OFF_TICKS = 12500000,
  parameter int CNT_W     = 26,
  parameter int MAX_LEN   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] length,
  output logic [3:0] seq_addr,
  input  logic [1:0] seq_symbol,
  output logic [1:0] disp_symbol,
  output logic       disp_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [4:0]       MAX_LEN_V = 5'(MAX_LEN);

`ifdef PLAYBACK_SPEEDUP_EN
  localparam int               ON_HALF      = (ON_TICKS / 2 < 1) ? 1 : ON_TICKS / 2;
  localparam logic [CNT_W-1:0] ON_HALF_LAST = CNT_W'(ON_HALF - 1);
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // 5-bit index so a 16-symbol playback can be compared against len=16
  // while the 4-bit address output wraps to 0.
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       len_q, len_d;
  logic [1:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] show_last;
  logic [4:0]       len_clamped;

  assign len_clamped = (length > MAX_LEN_V) ? MAX_LEN_V : length;

`ifdef PLAYBACK_SPEEDUP_EN
  assign show_last = (len_q > 5'd8) ? ON_HALF_LAST : ON_LAST;
`else
  assign show_last = ON_LAST;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sym_d   = sym_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        idx_d = 5'd0;
        cnt_d = '0;
        if (start) begin
          len_d = len_clamped;
          if (length != 5'd0) begin
            sym_d   = seq_symbol;
            valid_d = 1'b1;
            state_d = S_SHOW;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHOW: begin
        if (cnt_q == show_last) begin
          valid_d = 1'b0;
          idx_d   = idx_q + 5'd1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (idx_q == len_q) begin
            state_d = S_DONE;
          end else begin
            sym_d   = seq_symbol;
            valid_d = 1'b1;
            state_d = S_SHOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        idx_d   = 5'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      idx_d   = 5'd0;
      cnt_d   = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 5'd0;
      len_q   <= 5'd0;
      sym_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_addr    = idx_q[3:0];
  assign disp_symbol = sym_q;
  assign disp_valid  = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
module tb_sequence_playback_ctrl;

  localparam int ON_T  = 4;
  localparam int OFF_T = 2;
  localparam int PER   = ON_T + OFF_T;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] length;
  logic [3:0] seq_addr;
  logic [1:0] seq_symbol;
  logic [1:0] disp_symbol;
  logic       disp_valid;
  logic       busy;
  logic       done;

  logic [1:0] mem [16];

  int checks;
  int errors;

  assign seq_symbol = mem[seq_addr];

  sequence_playback_ctrl #(
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .CNT_W    (4),
    .MAX_LEN  (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .length     (length),
    .seq_addr   (seq_addr),
    .seq_symbol (seq_symbol),
    .disp_symbol(disp_symbol),
    .disp_valid (disp_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int on_for(input int l);
`ifdef PLAYBACK_SPEEDUP_EN
    return (l > 8) ? ON_T / 2 : ON_T;
`else
    return ON_T;
`endif
  endfunction

  // Pulses start with len_in and follows the playback cycle by cycle.
  // Cycle n is the n-th cycle after the accepting edge. Expected values come
  // from the timeline: symbol k visible for n in [1+k*P, k*P+on], done at
  // n = 1 + L*P, busy low at n = 2 + L*P.
  task automatic run_playback(input string name, input int len_in, input int l,
                              input bit noise);
    int on;
    int p;
    int k;
    int ph;
    logic       e_valid;
    logic [3:0] e_addr;
    logic       e_busy;
    logic       e_done;
    on = on_for(l);
    p  = on + OFF_T;
    @(negedge clock);
    length = 5'(len_in);
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= l * p + 2; n++) begin
      if (n <= l * p) begin
        k       = (n - 1) / p;
        ph      = (n - 1) % p;
        e_valid = (ph < on);
        e_addr  = e_valid ? 4'(k) : 4'((k + 1) % 16);
        e_busy  = 1'b1;
        e_done  = 1'b0;
      end else if (n == l * p + 1) begin
        k       = 0;
        e_valid = 1'b0;
        e_addr  = 4'(l % 16);
        e_busy  = 1'b1;
        e_done  = 1'b1;
      end else begin
        k       = 0;
        e_valid = 1'b0;
        e_addr  = 4'd0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
      end
      checks++;
      if (disp_valid !== e_valid) begin
        errors++;
        $display("FAIL %s valid n=%0d got %b exp %b", name, n, disp_valid, e_valid);
      end
      checks++;
      if (seq_addr !== e_addr) begin
        errors++;
        $display("FAIL %s addr n=%0d got %0d exp %0d", name, n, seq_addr, e_addr);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy n=%0d got %b exp %b", name, n, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL %s done n=%0d got %b exp %b", name, n, done, e_done);
      end
      if (e_valid) begin
        checks++;
        if (disp_symbol !== mem[k]) begin
          errors++;
          $display("FAIL %s symbol n=%0d got %0d exp %0d", name, n, disp_symbol, mem[k]);
        end
      end
      if (noise && (n == 3 || n == 8)) begin
        start  = 1'b1;
        length = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    length = 5'd0;
    repeat (2) @(negedge clock);
    checks++;
    if ({seq_addr, disp_symbol, disp_valid, busy, done} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {seq_addr, disp_symbol, disp_valid, busy, done});
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({seq_addr, disp_valid, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 0", {seq_addr, disp_valid, busy, done});
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 16; i++) mem[i] = 2'd1;
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
    run_playback("basic", 3, 3, 1'b0);
  endtask

  task automatic test_zero_length;
    run_playback("zero_len", 0, 0, 1'b0);
  endtask

  task automatic test_clamp_wrap;
    for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
    run_playback("clamp_wrap", 20, 16, 1'b0);
  endtask

  task automatic test_abort;
    int on;
    on = on_for(5);
    for (int i = 0; i < 16; i++) mem[i] = 2'(3 - (i % 4));
    @(negedge clock);
    length = 5'd5;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // advance into the second SHOW
    repeat (on + OFF_T + 1) @(negedge clock);
    checks++;
    if (disp_valid !== 1'b1 || seq_addr !== 4'd1) begin
      errors++;
      $display("FAIL abort_precond got valid=%b addr=%0d exp valid=1 addr=1", disp_valid, seq_addr);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({seq_addr, disp_valid, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL abort_idle got %b exp 0", {seq_addr, disp_valid, busy, done});
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (done !== 1'b0 || disp_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d done=%b valid=%b exp 0 0", i, done, disp_valid);
      end
      @(negedge clock);
    end
    run_playback("abort_replay", 5, 5, 1'b0);
  endtask

  task automatic test_ignored_start;
    for (int i = 0; i < 16; i++) mem[i] = 2'((i + 1) % 4);
    run_playback("busy_start", 4, 4, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < 16; i++) mem[i] = 2'd3;
    @(negedge clock);
    length = 5'd3;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // cycle 1 here; move to cycle ON_T+1, the first GAP cycle
    repeat (ON_T) @(negedge clock);
    checks++;
    if (disp_valid !== 1'b0 || busy !== 1'b1 || seq_addr !== 4'd1 || disp_symbol !== 2'd3) begin
      errors++;
      $display("FAIL rst_precond got v=%b b=%b a=%0d s=%0d exp 0 1 1 3",
               disp_valid, busy, seq_addr, disp_symbol);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({seq_addr, disp_symbol, disp_valid, busy, done} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {seq_addr, disp_symbol, disp_valid, busy, done});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({seq_addr, disp_valid, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp 0", {seq_addr, disp_valid, busy, done});
    end
  endtask

  task automatic test_speedup;
    for (int i = 0; i < 16; i++) mem[i] = 2'((i * 3) % 4);
    run_playback("len9", 9, 9, 1'b0);
    run_playback("len8", 8, 8, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    test_reset();
    test_basic();
    test_zero_length();
    test_clamp_wrap();
    test_abort();
    test_ignored_start();
    test_reset_mid_run();
    test_speedup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
